// File: rtl/instr_fetch.sv
// Instruction-fetch stage: program counter register plus an embedded
// asynchronous-read instruction ROM.
//
// Each rising clk edge the PC either loads inst_addr_in (on reset or a
// taken branch), holds (halt), or increments modulo 2**A. The ROM word at
// the current PC is presented combinationally on inst_out. The ROM
// contents are supplied by the environment through the "instructions" array.
module instr_fetch #(
   parameter int A = 4,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ctrl_branch,
   input  logic         take_branch,
   input  logic         halt,
   input  logic [A-1:0] inst_addr_in,
   output logic [A-1:0] inst_addr_out,
   output logic [W-1:0] inst_out
);

   logic [W-1:0] instructions [0:2**A-1];

   logic [A-1:0] pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= inst_addr_in;
      end else if (halt) begin
         pc <= pc;
      end else if (ctrl_branch && take_branch) begin
         pc <= inst_addr_in;
      end else begin
         pc <= pc + 1'b1;
      end
   end

   assign inst_addr_out = pc;

   assign inst_out = instructions[pc];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (A=4, W=9): PC sequencing, wrap, branch
// qualification, halt priority, reset-over-halt, and combinational ROM read.
module tb_instr_fetch;

    localparam int A = 4;
    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         ctrl_branch;
    logic         take_branch;
    logic         halt;
    logic [A-1:0] inst_addr_in;
    logic [A-1:0] inst_addr_out;
    logic [W-1:0] inst_out;

    int total = 0;
    int bad   = 0;

    instr_fetch #(.A(A), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl_branch   (ctrl_branch),
        .take_branch   (take_branch),
        .halt          (halt),
        .inst_addr_in  (inst_addr_in),
        .inst_addr_out (inst_addr_out),
        .inst_out      (inst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct ROM image: word(i) = 23*i + 5, all values below 512.
    function automatic logic [W-1:0] rom_word(input int i);
        return W'(23 * i + 5);
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check PC and the ROM word that must accompany it.
    task automatic check_pc(input string tag, input int exp_pc);
        chk({tag, ".pc"},   int'(inst_addr_out), exp_pc);
        chk({tag, ".inst"}, int'(inst_out),      int'(rom_word(exp_pc)));
    endtask

    initial begin
        for (int i = 0; i < 2**A; i++) begin
            dut.instructions[i] = rom_word(i);
        end

        reset        = 1'b1;
        ctrl_branch  = 1'b0;
        take_branch  = 1'b0;
        halt         = 1'b0;
        inst_addr_in = 4'd0;

        // 1. reset to 0, then free run
        step();
        check_pc("rst0", 0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_pc($sformatf("run%0d", k), k);
        end

        // 2. reset to 14 and wrap through 15 -> 0 -> 1
        reset        = 1'b1;
        inst_addr_in = 4'd14;
        step();
        check_pc("rst14", 14);
        reset = 1'b0;
        step();
        check_pc("wrap15", 15);
        step();
        check_pc("wrap0", 0);
        step();
        check_pc("wrap1", 1);

        // 3. ctrl_branch without take_branch, and the reverse: plain increment
        ctrl_branch  = 1'b1;
        take_branch  = 1'b0;
        inst_addr_in = 4'd9;
        step();
        check_pc("cb_only_a", 2);
        step();
        check_pc("cb_only_b", 3);
        ctrl_branch = 1'b0;
        take_branch = 1'b1;
        step();
        check_pc("tb_only", 4);
        take_branch = 1'b0;

        // No combinational bypass: new inputs must not move PC before the edge
        ctrl_branch  = 1'b1;
        take_branch  = 1'b1;
        inst_addr_in = 4'd12;
        #2;
        check_pc("no_bypass", 4);

        // 4. taken branch to 1, then resume incrementing
        inst_addr_in = 4'd1;
        step();
        check_pc("br_tgt", 1);
        ctrl_branch = 1'b0;
        take_branch = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            step();
            check_pc($sformatf("post_br%0d", k), k);
        end

        // 5. halt at 6 for 3 edges, middle edge carries a taken branch to 1
        halt = 1'b1;
        step();
        check_pc("halt_a", 6);
        ctrl_branch  = 1'b1;
        take_branch  = 1'b1;
        inst_addr_in = 4'd1;
        step();
        check_pc("halt_vs_br", 6);
        ctrl_branch = 1'b0;
        take_branch = 1'b0;
        step();
        check_pc("halt_c", 6);
        halt = 1'b0;
        step();
        check_pc("unhalt", 7);

        // 6. reset during halt wins, then resume from the reset address
        halt         = 1'b1;
        reset        = 1'b1;
        inst_addr_in = 4'd5;
        step();
        check_pc("rst_in_halt", 5);
        reset = 1'b0;
        halt  = 1'b0;
        step();
        check_pc("resume6", 6);
        step();
        check_pc("resume7", 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
